// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if
//
// Request/status bundle between an upstream command source and sr_latch_driver.
//
// Signals:
//   req_valid  request present (held by upstream until accepted)
//   req_op     00 ENABLE, 01 CLEAR, 10 SET, 11 DISABLE
//   req_ready  driver is idle and will accept a request this cycle
//   busy       driver is sequencing (SETUP, PULSE or GUARD)
//   done       one-cycle pulse when an accepted request completes
//   err        one-cycle pulse when a SET/CLEAR is rejected (latch disabled)
//
// Modports:
//   master  upstream command source
//   slave   sr_latch_driver
interface sr_latch_driver_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req_valid,
        output req_op,
        input  req_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_op,
        output req_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//
// Clocked command sequencer for a level-sensitive SR latch. Each accepted SET or
// CLEAR is widened into a timed s or r pulse, framed by a setup guard (en=1, s=r=0)
// before and a hold guard after. ENABLE/DISABLE change en and are followed by a
// hold guard. s and r are never high together and never high while en is low.
// q_model tracks the expected latch output so upstream logic never has to sample
// the asynchronous latch.
//
// Parameters:
//   SETUP_W  guard cycles before a pulse (1..255)
//   PULSE_W  cycles s or r is held high (1..255)
//   HOLD_W   guard cycles after a pulse or an en change (1..255)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   req       sr_latch_driver_if.slave: req_valid/req_op in, req_ready/busy/done/err out
//   en        latch enable
//   s         latch set
//   r         latch reset
//   q_model   expected latch q
//   q_fb      (readback build only) raw latch q, synchronized internally
//   mismatch  (readback build only) sticky: synchronized q_fb differed from q_model in IDLE
//
// Optional feature macro: SR_LATCH_DRIVER_READBACK_EN adds q_fb/mismatch and a 2-flop
// synchronizer. Without it the module has no readback logic at all.
//
// All outputs come straight from flops; there is no combinational path from req_*
// to en/s/r.
module sr_latch_driver #(
    parameter int unsigned SETUP_W = 1,
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned HOLD_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    sr_latch_driver_if.slave    req,
    output logic                en,
    output logic                s,
    output logic                r,
    output logic                q_model
`ifdef SR_LATCH_DRIVER_READBACK_EN
    ,
    input  logic                q_fb,
    output logic                mismatch
`endif
);

    typedef enum logic [1:0] {
        OpEnable  = 2'b00,
        OpClear   = 2'b01,
        OpSet     = 2'b10,
        OpDisable = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StPulse,
        StGuard
    } state_e;

    // Phase counters are loaded with length-1 and the phase ends on the cycle
    // the counter reads zero, so a length of N occupies exactly N cycles.
    localparam logic [7:0] SetupLd = 8'(SETUP_W - 1);
    localparam logic [7:0] PulseLd = 8'(PULSE_W - 1);
    localparam logic [7:0] HoldLd  = 8'(HOLD_W - 1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       en_q;
    logic       s_q;
    logic       r_q;
    logic       q_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       ready_q;
    logic       is_set_q;   // remembers whether the pending pulse is s (1) or r (0)

    logic       accept;
    op_e        op;

    assign op     = op_e'(req.req_op);
    // ready_q is only ever high in IDLE, so this is the handshake.
    assign accept = req.req_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            en_q     <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            q_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            is_set_q <= 1'b0;
        end else begin
            // done/err are single-cycle strobes.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        unique case (op)
                            OpEnable: begin
                                en_q    <= 1'b1;
                                state_q <= StGuard;
                                cnt_q   <= HoldLd;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                            end
                            OpDisable: begin
                                // The latch cannot be driven while disabled, so
                                // the model is forced to its safe value.
                                en_q    <= 1'b0;
                                q_q     <= 1'b0;
                                state_q <= StGuard;
                                cnt_q   <= HoldLd;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b0;
                            end
                            OpSet, OpClear: begin
                                if (en_q) begin
                                    is_set_q <= (op == OpSet);
                                    state_q  <= StSetup;
                                    cnt_q    <= SetupLd;
                                    busy_q   <= 1'b1;
                                    ready_q  <= 1'b0;
                                end else begin
                                    // Rejected: nothing but err moves.
                                    err_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StSetup: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StPulse;
                        cnt_q   <= PulseLd;
                        s_q     <= is_set_q;
                        r_q     <= !is_set_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StPulse: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StGuard;
                        cnt_q   <= HoldLd;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        // The latch has seen the full pulse; commit the model.
                        q_q     <= is_set_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StGuard: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign en            = en_q;
    assign s             = s_q;
    assign r             = r_q;
    assign q_model       = q_q;
    assign req.req_ready = ready_q;
    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.err       = err_q;

`ifdef SR_LATCH_DRIVER_READBACK_EN
    // q_fb comes from an asynchronous latch; two flops before it is trusted.
    logic q_fb_meta_q;
    logic q_fb_sync_q;
    logic mismatch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_fb_meta_q <= 1'b0;
            q_fb_sync_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            q_fb_meta_q <= q_fb;
            q_fb_sync_q <= q_fb_meta_q;
            if (accept) begin
                mismatch_q <= 1'b0;
            end else if ((state_q == StIdle) && (q_fb_sync_q != q_q)) begin
                // Only compared in IDLE: during a sequence the latch and the
                // model legitimately disagree for a few cycles.
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
//
// Cycle-accurate scoreboard bench for sr_latch_driver. Stimulus tasks push one
// record per clock cycle (inputs to drive plus the output vector expected after
// the next edge); drain() replays the records and compares. Instance A uses the
// default timing, instance B uses SETUP_W=3, PULSE_W=1, HOLD_W=1.
module tb_sr_latch_driver;

    localparam logic [1:0] OpEnable  = 2'b00;
    localparam logic [1:0] OpClear   = 2'b01;
    localparam logic [1:0] OpSet     = 2'b10;
    localparam logic [1:0] OpDisable = 2'b11;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    sr_latch_driver_if ifa ();
    sr_latch_driver_if ifb ();

    logic en_a, s_a, r_a, q_a;
    logic en_b, s_b, r_b, q_b;

`ifdef SR_LATCH_DRIVER_READBACK_EN
    logic fb_a = 1'b0;
    logic fb_b = 1'b0;
    logic mm_a, mm_b;
`endif

    sr_latch_driver dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .req      (ifa),
        .en       (en_a),
        .s        (s_a),
        .r        (r_a),
        .q_model  (q_a)
`ifdef SR_LATCH_DRIVER_READBACK_EN
        ,
        .q_fb     (fb_a),
        .mismatch (mm_a)
`endif
    );

    sr_latch_driver #(
        .SETUP_W (3),
        .PULSE_W (1),
        .HOLD_W  (1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .req      (ifb),
        .en       (en_b),
        .s        (s_b),
        .r        (r_b),
        .q_model  (q_b)
`ifdef SR_LATCH_DRIVER_READBACK_EN
        ,
        .q_fb     (fb_b),
        .mismatch (mm_b)
`endif
    );

    // Observed vector order: {ready, busy, done, err, en, s, r, q_model}
    wire [7:0] obs_a = {ifa.req_ready, ifa.busy, ifa.done, ifa.err, en_a, s_a, r_a, q_a};
    wire [7:0] obs_b = {ifb.req_ready, ifb.busy, ifb.done, ifb.err, en_b, s_b, r_b, q_b};

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [1:0] op;
        logic [7:0] exp;
    } rec_t;

    rec_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic model_en = 1'b0;
    logic model_q  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vec(input logic rdy, input logic bsy, input logic dn,
                                       input logic er, input logic e, input logic ss,
                                       input logic rr, input logic q);
        return {rdy, bsy, dn, er, e, ss, rr, q};
    endfunction

    task automatic push(input logic rs, input logic v, input logic [1:0] op,
                        input logic [7:0] exp);
        rec_t rc;
        rc.rst   = rs;
        rc.valid = v;
        rc.op    = op;
        rc.exp   = exp;
        sbq.push_back(rc);
    endtask

    task automatic push_rst(input int n);
        model_en = 1'b0;
        model_q  = 1'b0;
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, 2'b00, vec(1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            push(1'b0, 1'b0, 2'b00, vec(1, 0, 0, 0, model_en, 0, 0, model_q));
        end
    endtask

    // Push one request: expected outputs for cycles 1..done, with the request
    // presented in cycle 0. With hold set, req_valid stays high carrying hold_op
    // while the driver is busy. max_cyc truncates the trace (for mid-sequence reset).
    task automatic push_req(input int sw, input int pw, input int hw, input logic [1:0] op,
                            input logic hold, input logic [1:0] hold_op, input int max_cyc);
        logic [7:0] e[$];
        logic       is_set;
        logic       q0;
        q0 = model_q;
        if (op == OpEnable || op == OpDisable) begin
            model_en = (op == OpEnable);
            if (!model_en) model_q = 1'b0;
            for (int k = 0; k < hw; k++) e.push_back(vec(0, 1, 0, 0, model_en, 0, 0, model_q));
            e.push_back(vec(1, 0, 1, 0, model_en, 0, 0, model_q));
        end else if (!model_en) begin
            e.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0));
        end else begin
            is_set = (op == OpSet);
            for (int k = 0; k < sw; k++) e.push_back(vec(0, 1, 0, 0, 1, 0, 0, q0));
            for (int k = 0; k < pw; k++) e.push_back(vec(0, 1, 0, 0, 1, is_set, !is_set, q0));
            for (int k = 0; k < hw; k++) e.push_back(vec(0, 1, 0, 0, 1, 0, 0, is_set));
            e.push_back(vec(1, 0, 1, 0, 1, 0, 0, is_set));
            model_q = is_set;
        end
        for (int k = 0; k < e.size() && k < max_cyc; k++) begin
            if (k == 0)    push(1'b0, 1'b1, op, e[k]);
            else if (hold) push(1'b0, 1'b1, hold_op, e[k]);
            else           push(1'b0, 1'b0, 2'b00, e[k]);
        end
    endtask

    task automatic drain(input bit sel, input string tag);
        rec_t rc;
        int   i;
        i = 0;
        while (sbq.size() > 0) begin
            rc = sbq.pop_front();
            if (sel) begin
                rst_b = rc.rst; ifb.req_valid = rc.valid; ifb.req_op = rc.op;
            end else begin
                rst_a = rc.rst; ifa.req_valid = rc.valid; ifa.req_op = rc.op;
            end
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), sel ? obs_b : obs_a, rc.exp);
            i++;
        end
        if (sel) begin
            rst_b = 1'b0; ifb.req_valid = 1'b0;
        end else begin
            rst_a = 1'b0; ifa.req_valid = 1'b0;
        end
    endtask

    initial begin
        ifa.req_valid = 1'b0;
        ifa.req_op    = 2'b00;
        ifb.req_valid = 1'b0;
        ifb.req_op    = 2'b00;

        // Instance A, default timing 1/4/2. B is held in reset meanwhile.
        push_rst(3);
        push_req(1, 4, 2, OpSet, 0, 2'b00, 99);           // rejected: disabled
        push_idle(2);
        drain(0, "a_reset_reject");

        push_req(1, 4, 2, OpEnable, 0, 2'b00, 99);
        push_idle(1);
        push_req(1, 4, 2, OpSet, 0, 2'b00, 99);
        push_idle(1);
        push_req(1, 4, 2, OpClear, 0, 2'b00, 99);
        push_req(1, 4, 2, OpEnable, 0, 2'b00, 99);        // back-to-back, already enabled
        push_req(1, 4, 2, OpSet, 0, 2'b00, 99);
        push_req(1, 4, 2, OpDisable, 0, 2'b00, 99);       // drops q_model with en
        push_req(1, 4, 2, OpDisable, 0, 2'b00, 99);       // already disabled
        push_idle(1);
        drain(0, "a_seq");

        // Reset during the third pulse cycle of a SET.
        push_req(1, 4, 2, OpEnable, 0, 2'b00, 99);
        push_req(1, 4, 2, OpSet, 0, 2'b00, 4);
        push_rst(1);
        push_idle(3);
        drain(0, "a_mid_rst");

        // Instance B, 3/1/1, with req_valid held high across SET -> CLEAR.
        push_rst(2);
        push_req(3, 1, 1, OpEnable, 0, 2'b00, 99);
        push_req(3, 1, 1, OpSet, 1, OpClear, 99);
        push_req(3, 1, 1, OpClear, 0, 2'b00, 99);
        push_idle(2);
        drain(1, "b_seq");

`ifdef SR_LATCH_DRIVER_READBACK_EN
        begin
            int n;
            push_req(1, 4, 2, OpEnable, 0, 2'b00, 99);
            drain(0, "rb_en");
            fb_a = 1'b1;                                  // latch will follow the SET
            push_req(1, 4, 2, OpSet, 0, 2'b00, 99);
            push_idle(3);
            drain(0, "rb_set");
            check("rb_mismatch_clean", {7'd0, mm_a}, 8'd0);
            fb_a = 1'b0;                                  // latch disagrees with model
            n = 0;
            while (mm_a !== 1'b1 && n < 6) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("rb_mismatch_set", {7'd0, mm_a}, 8'd1);
            push_req(1, 4, 2, OpClear, 0, 2'b00, 99);
            drain(0, "rb_clear");
            check("rb_mismatch_cleared", {7'd0, mm_a}, 8'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
